// File: rtl/mrsc_decoder.sv
// mrsc_decoder: three-stage pipelined decoder for the 32-bit MRSC codeword.
// Recovers 16 data bits, corrects single-row data errors and single check-bit
// errors, flags everything else as uncorrectable, and keeps saturating
// corrected/uncorrectable counters. Valid/ready handshake on both sides.
module mrsc_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:31]      code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:15]      data_out,
  output logic [1:0]       err_status,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_uncorr,
  input  logic             clr_cnt
);

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // XOR-reduction of a 4-bit group (one parity equation)
  function automatic logic xor4(input logic [3:0] v);
    return ^v;
  endfunction

  // True when exactly one bit of v is set
  function automatic logic onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  // Pipeline state
  logic             adv_s;
  logic             v1_r;
  logic [0:31]      code1_r;
  logic             v2_r;
  logic [15:0]      raw2_r;
  logic [3:0]       sp2_r;
  logic [3:0]       fix2_r;
  logic [1:0]       st2_r;

  // Stage-2 combinational decode of the stage-1 codeword
  logic [3:0][3:0]  d_s;
  logic [3:0][1:0]  sc_s;
  logic [3:0]       p_s;
  logic [3:0]       sp_s;
  logic [3:0]       sd_s;
  logic [3:0]       row_nz_s;
  logic [1:0]       sel_sc_s;
  logic [3:0]       pred_s;
  logic [1:0]       st_s;
  logic [3:0]       fix_s;

  // Stage-3 combinational correction
  logic [3:0]       emask_s;
  logic [15:0]      corr_s;

  // A stage moves only when the output register is free or being drained
  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  // Syndrome generation and error classification for the word in stage 1
  always_comb begin
    d_s      = '0;
    sc_s     = '0;
    p_s      = '0;
    sp_s     = '0;
    sd_s     = '0;
    row_nz_s = '0;
    sel_sc_s = 2'b00;
    pred_s   = '0;
    st_s     = ST_UNCORR;
    fix_s    = 4'h0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        d_s[r][k] = code1_r[8*r+k];
      end
      sc_s[r][0]  = code1_r[8*r+6] ^ d_s[r][0] ^ d_s[r][2];
      sc_s[r][1]  = code1_r[8*r+7] ^ d_s[r][1] ^ d_s[r][3];
      row_nz_s[r] = |sc_s[r];
      sel_sc_s    = sel_sc_s | (row_nz_s[r] ? sc_s[r] : 2'b00);
    end
    // Column parity bits live in the pair slots of rows 2 and 3
    p_s[0] = code1_r[20];
    p_s[1] = code1_r[28];
    p_s[2] = code1_r[21];
    p_s[3] = code1_r[29];
    for (int k = 0; k < 4; k++) begin
      sp_s[k] = p_s[k] ^ xor4({d_s[0][k], d_s[1][k], d_s[2][k], d_s[3][k]});
    end
    // Diagonal bits live in the pair slots of rows 0 and 1
    sd_s[0] = code1_r[4]  ^ xor4({d_s[0][0], d_s[1][1], d_s[2][0], d_s[3][1]});
    sd_s[1] = code1_r[12] ^ xor4({d_s[0][1], d_s[1][0], d_s[2][1], d_s[3][0]});
    sd_s[2] = code1_r[5]  ^ xor4({d_s[0][2], d_s[1][3], d_s[2][2], d_s[3][3]});
    sd_s[3] = code1_r[13] ^ xor4({d_s[0][3], d_s[1][2], d_s[2][3], d_s[3][2]});
    // Odd rows see the diagonal pattern with neighbouring columns swapped
    if (row_nz_s[1] || row_nz_s[3]) begin
      pred_s = {sp_s[2], sp_s[3], sp_s[0], sp_s[1]};
    end else begin
      pred_s = sp_s;
    end
    if ((row_nz_s == 4'h0) && (sp_s == 4'h0) && (sd_s == 4'h0)) begin
      st_s = ST_CLEAN;
    end else if (onehot8({4'h0, row_nz_s}) && (sp_s == 4'h0) && (sd_s == 4'h0)) begin
      st_s = ST_CORR;
    end else if (onehot8({4'h0, row_nz_s}) &&
                 (sel_sc_s[0] == (sp_s[0] ^ sp_s[2])) &&
                 (sel_sc_s[1] == (sp_s[1] ^ sp_s[3])) &&
                 (sd_s == pred_s)) begin
      st_s  = ST_CORR;
      fix_s = row_nz_s;
    end else if ((row_nz_s == 4'h0) && onehot8({sp_s, sd_s})) begin
      st_s = ST_CORR;
    end else begin
      st_s = ST_UNCORR;
    end
  end

  // Apply the registered flip vector to the selected row (row 0 is the MSB nibble)
  always_comb begin
    emask_s = {sp2_r[0], sp2_r[1], sp2_r[2], sp2_r[3]};
    corr_s  = raw2_r ^ {(fix2_r[0] ? emask_s : 4'h0),
                        (fix2_r[1] ? emask_s : 4'h0),
                        (fix2_r[2] ? emask_s : 4'h0),
                        (fix2_r[3] ? emask_s : 4'h0)};
  end

  // Stage 1: capture the incoming codeword
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      code1_r <= 32'h0000_0000;
    end else if (adv_s) begin
      v1_r    <= in_valid;
      code1_r <= code_in;
    end
  end

  // Stage 2: capture syndromes, decision and raw data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r   <= 1'b0;
      raw2_r <= 16'h0000;
      sp2_r  <= 4'h0;
      fix2_r <= 4'h0;
      st2_r  <= ST_CLEAN;
    end else if (adv_s) begin
      v2_r   <= v1_r;
      raw2_r <= {code1_r[0:3], code1_r[8:11], code1_r[16:19], code1_r[24:27]};
      sp2_r  <= sp_s;
      fix2_r <= fix_s;
      st2_r  <= st_s;
    end
  end

  // Stage 3: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      data_out   <= 16'h0000;
      err_status <= ST_CLEAN;
    end else if (adv_s) begin
      out_valid  <= v2_r;
      data_out   <= corr_s;
      err_status <= st2_r;
    end
  end

  // Saturating statistics, counted on output acceptance; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (clr_cnt) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (out_valid && out_ready) begin
      case (err_status)
        ST_CORR: begin
          if (cnt_corr != CNT_MAX) cnt_corr <= cnt_corr + CNT_ONE;
        end
        ST_UNCORR: begin
          if (cnt_uncorr != CNT_MAX) cnt_uncorr <= cnt_uncorr + CNT_ONE;
        end
        default: begin
          cnt_corr   <= cnt_corr;
          cnt_uncorr <= cnt_uncorr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mrsc_decoder.sv
// tb_mrsc_decoder: directed self-checking bench for mrsc_decoder.
module tb_mrsc_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, clr_cnt;
  logic [0:31] code_in;
  logic [0:15] data_out;
  logic [1:0]  err_status;
  logic [15:0] cnt_corr, cnt_uncorr;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, clr_cnt4;
  logic [0:31] code_in4;
  logic [0:15] data_out4;
  logic [1:0]  err_status4;
  logic [3:0]  cnt_corr4, cnt_uncorr4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:15] rd;
  logic [1:0]  rs;
  int          rl;

  mrsc_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .code_in(code_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err_status(err_status), .cnt_corr(cnt_corr),
    .cnt_uncorr(cnt_uncorr), .clr_cnt(clr_cnt)
  );

  mrsc_decoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .code_in(code_in4), .out_valid(out_valid4), .out_ready(out_ready4),
    .data_out(data_out4), .err_status(err_status4), .cnt_corr(cnt_corr4),
    .cnt_uncorr(cnt_uncorr4), .clr_cnt(clr_cnt4)
  );

  always #5 clk = ~clk;

  // Encoder model used only to build clean stimulus words
  function automatic logic [0:31] encode(input logic [0:15] dv);
    logic [0:31] cw;
    cw = 32'h0000_0000;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) cw[8*r+k] = dv[4*r+k];
      cw[8*r+6] = dv[4*r]   ^ dv[4*r+2];
      cw[8*r+7] = dv[4*r+1] ^ dv[4*r+3];
    end
    cw[20] = dv[0] ^ dv[4] ^ dv[8]  ^ dv[12];
    cw[28] = dv[1] ^ dv[5] ^ dv[9]  ^ dv[13];
    cw[21] = dv[2] ^ dv[6] ^ dv[10] ^ dv[14];
    cw[29] = dv[3] ^ dv[7] ^ dv[11] ^ dv[15];
    cw[4]  = dv[0] ^ dv[5] ^ dv[8]  ^ dv[13];
    cw[12] = dv[1] ^ dv[4] ^ dv[9]  ^ dv[12];
    cw[5]  = dv[2] ^ dv[7] ^ dv[10] ^ dv[15];
    cw[13] = dv[3] ^ dv[6] ^ dv[11] ^ dv[14];
    return cw;
  endfunction

  // Push one word, wait (bounded) for its result, then let it be consumed
  task automatic send_word(input logic [0:31] cw, output logic [0:15] d,
                           output logic [1:0] st, output int lat);
    in_valid  = 1'b1;
    code_in   = cw;
    out_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 12);
    d  = data_out;
    st = err_status;
    if (!out_valid) lat = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", data_out); end
    n_checks++; if (err_status !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b expected 00", err_status); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (cnt_corr !== 16'h0 || cnt_uncorr !== 16'h0) begin n_fail++; $display("FAIL reset_counters: got %h/%h expected 0/0", cnt_corr, cnt_uncorr); end
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    send_word(32'h0000_0000, rd, rs, rl);
    n_checks++; if (rl !== 3) begin n_fail++; $display("FAIL clean_latency: got %0d expected 3", rl); end
    n_checks++; if (rd !== 16'h0000 || rs !== 2'b00) begin n_fail++; $display("FAIL clean_zero: got %h/%b expected 0000/00", rd, rs); end
    send_word(32'hF0F0_F0F0, rd, rs, rl);
    n_checks++; if (rd !== 16'hFFFF || rs !== 2'b00) begin n_fail++; $display("FAIL clean_ones: got %h/%b expected ffff/00", rd, rs); end
    send_word(32'hAC00_0C00, rd, rs, rl);
    n_checks++; if (rd !== 16'hA000 || rs !== 2'b00) begin n_fail++; $display("FAIL clean_a000: got %h/%b expected a000/00", rd, rs); end
    n_checks++; if (cnt_corr !== 16'h0 || cnt_uncorr !== 16'h0) begin n_fail++; $display("FAIL clean_counters: got %h/%h expected 0/0", cnt_corr, cnt_uncorr); end
  endtask

  task automatic test_single_error();
    logic [0:31] cw;
    logic [0:31] flip;
    send_word(32'h4000_0000, rd, rs, rl);
    n_checks++; if (rd !== 16'h0000 || rs !== 2'b01) begin n_fail++; $display("FAIL single_c1: got %h/%b expected 0000/01", rd, rs); end
    n_checks++; if (cnt_corr !== 16'd1) begin n_fail++; $display("FAIL single_cnt1: got %0d expected 1", cnt_corr); end
    send_word(32'hAC20_0C00, rd, rs, rl);
    n_checks++; if (rd !== 16'hA000 || rs !== 2'b01) begin n_fail++; $display("FAIL single_row1: got %h/%b expected a000/01", rd, rs); end
    for (int i = 0; i < 32; i++) begin
      flip = 32'h8000_0000 >> i;
      cw   = 32'hF0F0_F0F0 ^ flip;
      send_word(cw, rd, rs, rl);
      n_checks++;
      if (rd !== 16'hFFFF || rs !== 2'b01) begin
        n_fail++; $display("FAIL sweep_bit%0d: got %h/%b expected ffff/01", i, rd, rs);
      end
    end
    n_checks++; if (cnt_corr !== 16'd34) begin n_fail++; $display("FAIL single_cnt34: got %0d expected 34", cnt_corr); end
  endtask

  task automatic test_uncorrectable();
    send_word(32'h7070_F0F0, rd, rs, rl);
    n_checks++; if (rd !== 16'h77FF || rs !== 2'b10) begin n_fail++; $display("FAIL uncorr_two_rows: got %h/%b expected 77ff/10", rd, rs); end
    n_checks++; if (cnt_uncorr !== 16'd1) begin n_fail++; $display("FAIL uncorr_cnt1: got %0d expected 1", cnt_uncorr); end
    send_word(32'h0800_0800, rd, rs, rl);
    n_checks++; if (rd !== 16'h0000 || rs !== 2'b10) begin n_fail++; $display("FAIL uncorr_two_checks: got %h/%b expected 0000/10", rd, rs); end
    n_checks++; if (cnt_uncorr !== 16'd2 || cnt_corr !== 16'd34) begin n_fail++; $display("FAIL uncorr_cnts: got %0d/%0d expected 34/2", cnt_corr, cnt_uncorr); end
  endtask

  task automatic test_back_to_back();
    logic [0:15] exp_d [8];
    logic [0:15] held_d;
    logic [1:0]  held_s;
    int tx, rx, first_acc, first_out;
    logic stalled_prev;
    exp_d = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978};
    tx = 0; rx = 0; first_acc = -1; first_out = -1; stalled_prev = 1'b0;
    held_d = 16'h0000; held_s = 2'b00;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (stalled_prev) begin
        n_checks++;
        if (out_valid !== 1'b1 || data_out !== held_d || err_status !== held_s) begin
          n_fail++; $display("FAIL b2b_hold_c%0d: got %b/%h/%b expected 1/%h/%b", cyc, out_valid, data_out, err_status, held_d, held_s);
        end
      end
      if (out_valid && first_out < 0) first_out = cyc;
      out_ready = !(cyc >= 6 && cyc < 11);
      in_valid  = (tx < 8);
      code_in   = (tx < 8) ? encode(exp_d[tx]) : 32'h0000_0000;
      #1;
      if (out_valid && !out_ready) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_c%0d: got %b expected 0", cyc, in_ready); end
        held_d = data_out; held_s = err_status; stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (rx >= 8) begin
          n_fail++; $display("FAIL b2b_extra: got word %h expected none", data_out);
        end else if (data_out !== exp_d[rx] || err_status !== 2'b00) begin
          n_fail++; $display("FAIL b2b_word%0d: got %h/%b expected %h/00", rx, data_out, err_status, exp_d[rx]);
        end
        rx++;
      end
      if (in_valid && in_ready) begin
        if (tx == 0) first_acc = cyc;
        tx++;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (rx !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", rx); end
    n_checks++; if (first_out - first_acc !== 3) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 3", first_out - first_acc); end
  endtask

  task automatic test_counters();
    int wait_n;
    in_valid4 = 1'b1; code_in4 = 32'h4000_0000; out_ready4 = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    in_valid4 = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (cnt_corr4 !== 4'hF) begin n_fail++; $display("FAIL cnt_saturate: got %h expected f", cnt_corr4); end
    n_checks++; if (cnt_uncorr4 !== 4'h0) begin n_fail++; $display("FAIL cnt_uncorr_idle: got %h expected 0", cnt_uncorr4); end
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    wait_n = 0;
    while (!out_valid4 && wait_n < 10) begin @(posedge clk); #1; wait_n++; end
    n_checks++; if (out_valid4 !== 1'b1) begin n_fail++; $display("FAIL cnt_wait: got out_valid %b expected 1", out_valid4); end
    clr_cnt4 = 1'b1;
    @(posedge clk); #1;
    clr_cnt4 = 1'b0;
    n_checks++; if (cnt_corr4 !== 4'h0) begin n_fail++; $display("FAIL cnt_clear_wins: got %h expected 0", cnt_corr4); end
    n_checks++; if (out_valid4 !== 1'b0) begin n_fail++; $display("FAIL cnt_consumed: got %b expected 0", out_valid4); end
  endtask

  task automatic test_reset_midstream();
    int stale;
    logic [0:31] words [3];
    words = '{encode(16'hBEEF), encode(16'hCAFE), 32'h7070_F0F0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; code_in = words[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || data_out !== 16'hBEEF) begin n_fail++; $display("FAIL mid_inflight: got %b/%h expected 1/beef", out_valid, data_out); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (data_out !== 16'h0000 || err_status !== 2'b00) begin n_fail++; $display("FAIL mid_outputs: got %h/%b expected 0000/00", data_out, err_status); end
    n_checks++; if (cnt_corr !== 16'h0 || cnt_uncorr !== 16'h0) begin n_fail++; $display("FAIL mid_counters: got %h/%h expected 0/0", cnt_corr, cnt_uncorr); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL mid_stale: got %0d stale cycles expected 0", stale); end
    send_word(encode(16'h0F0F), rd, rs, rl);
    n_checks++; if (rd !== 16'h0F0F || rs !== 2'b00 || rl !== 3) begin n_fail++; $display("FAIL mid_restart: got %h/%b lat %0d expected 0f0f/00 lat 3", rd, rs, rl); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0; code_in = 32'h0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; clr_cnt4 = 1'b0; code_in4 = 32'h0;
    test_reset();
    test_clean();
    test_single_error();
    test_uncorrectable();
    test_back_to_back();
    test_counters();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
